top: RTL and testbench

Clocked decision-tree classifier for the 9-feature breast-cancer dataset. It takes nine 8-bit quantised features, evaluates a fixed binary decision tree of unsigned threshold comparisons, and registers a 2-bit class label. It is the top level of the printed-classifier datapath. Upstream logic drives the feature bus and downstream logic samples `out`.

---
 rtl/top.sv | 32 +++
 tb/tb_top.sv | 99 +++++++++
 2 files changed

// File: rtl/top.sv
// top: breast-cancer decision-tree classifier; in clk, rst (async high), X0..X8 [7:0] features; out [1:0] registered label (0 benign, 1 malignant)
module top (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] X0,
  input  logic [7:0] X1,
  input  logic [7:0] X2,
  input  logic [7:0] X3,
  input  logic [7:0] X4,
  input  logic [7:0] X5,
  input  logic [7:0] X6,
  input  logic [7:0] X7,
  input  logic [7:0] X8,
  output logic [1:0] out
);
  logic       n3, n4, n5, n6, n1, n2, lbl;
  logic [1:0] out_d, out_q;
  always_comb begin
    n3    = (X7 <= 8'd140) ? 1'b0 : (X0 > 8'd150);
    n4    = X0 > 8'd90;
    n1    = (X5 <= 8'd100) ? n3 : n4;
    n5    = (X6 <= 8'd80) ? (X4 > 8'd60) : 1'b1;
    n6    = (X3 <= 8'd50) ? (X8 > 8'd30) : 1'b1;
    n2    = (X2 <= 8'd110) ? n5 : n6;
    lbl   = (X1 <= 8'd72) ? n1 : n2;
    out_d = {1'b0, lbl};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) out_q <= 2'd0;
    else     out_q <= out_d;
  assign out = out_q;
endmodule

// File: tb/tb_top.sv
// tb_top: scoreboard bench for the decision-tree classifier
module tb_top;
  logic            clk = 1'b0;
  logic            rst;
  logic [8:0][7:0] x;
  logic [1:0]      out;
  logic [1:0]      exp_q[$];
  int              total = 0;
  int              bad = 0;

  top dut (
    .clk(clk), .rst(rst),
    .X0(x[0]), .X1(x[1]), .X2(x[2]), .X3(x[3]), .X4(x[4]),
    .X5(x[5]), .X6(x[6]), .X7(x[7]), .X8(x[8]),
    .out(out)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] tree(input logic [8:0][7:0] v);
    if (v[1] <= 72) begin
      if (v[5] <= 100) begin
        if (v[7] <= 140) return 2'd0;
        return (v[0] <= 150) ? 2'd0 : 2'd1;
      end
      return (v[0] <= 90) ? 2'd0 : 2'd1;
    end
    if (v[2] <= 110) begin
      if (v[6] > 80) return 2'd1;
      return (v[4] <= 60) ? 2'd0 : 2'd1;
    end
    if (v[3] > 50) return 2'd1;
    return (v[8] <= 30) ? 2'd0 : 2'd1;
  endfunction

  task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic step(input string tag, input logic [8:0][7:0] v, input logic [1:0] e);
    @(negedge clk);
    x = v;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    chk(tag, out, exp_q.pop_front());
  endtask

  initial begin
    logic [8:0][7:0] v;
    rst = 1'b1;
    x = {9{8'd255}};
    repeat (3) @(posedge clk);
    #1 chk("reset", out, 2'd0);
    @(negedge clk) rst = 1'b0;
    step("rel_255", {9{8'd255}}, 2'd1);
    step("zeros", '0, 2'd0);
    v = '0; v[1] = 72; v[5] = 101; v[0] = 90;
    step("n4_eq", v, 2'd0);
    v[0] = 91;
    step("n4_gt", v, 2'd1);
    v = '0; v[1] = 73;
    step("n0_gt", v, 2'd0);
    v = '0; v[1] = 73; v[2] = 110; v[6] = 80; v[4] = 60;
    step("n8_eq", v, 2'd0);
    v[4] = 61;
    step("n8_gt", v, 2'd1);
    v[6] = 81;
    step("n5_gt", v, 2'd1);
    v = '0; v[1] = 73; v[2] = 111; v[3] = 50; v[8] = 30;
    step("n9_eq", v, 2'd0);
    v[8] = 31;
    step("n9_gt", v, 2'd1);
    v = '0; v[7] = 141; v[0] = 150;
    step("n7_eq", v, 2'd0);
    v[0] = 151;
    step("n7_gt", v, 2'd1);
    step("pre_rst", {9{8'd255}}, 2'd1);
    #2 rst = 1'b1;
    #1 chk("async_rst", out, 2'd0);
    #1 rst = 1'b0;
    step("post_rst", {9{8'd255}}, 2'd1);
    x = '0;
    #2 chk("hold", out, 2'd1);
    @(posedge clk);
    #1 chk("hold_upd", out, 2'd0);
    for (int i = 0; i < 10000; i++) begin
      for (int j = 0; j < 9; j++) v[j] = 8'($urandom_range(0, 255));
      step("rand", v, tree(v));
      chk("msb", {1'b0, out[1]}, 2'd0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
